// File: rtl/core_pkg.sv
// Shared constants and types for the 16-bit core's issue and operand-fetch path.
package core_pkg;

    localparam int DW   = 16;
    localparam int AW   = 4;
    localparam int OPW  = 4;
    localparam int NREG = 2 ** AW;

    // ALU opcodes carried from decode through to execute, untouched by this stage.
    typedef enum logic [OPW-1:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_XOR   = 4'h4,
        ALU_NOT   = 4'h5,
        ALU_SHL   = 4'h6,
        ALU_SHR   = 4'h7,
        ALU_SRA   = 4'h8,
        ALU_ROL   = 4'h9,
        ALU_ROR   = 4'hA,
        ALU_PASSA = 4'hB,
        ALU_PASSB = 4'hC,
        ALU_SLT   = 4'hD,
        ALU_SLTU  = 4'hE,
        ALU_NOP   = 4'hF
    } alu_op_e;

    // One issued instruction as held in the output pipeline register.
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          we;
        alu_op_e       op;
    } issue_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, write-back and execute signals seen by operand fetch.
interface operand_fetch_if;
    import core_pkg::*;

    logic          id_valid;
    logic          id_ready;
    logic [AW-1:0] id_ra;
    logic [AW-1:0] id_rb;
    logic [AW-1:0] id_rd;
    logic          id_we;
    logic          id_use_imm;
    logic [DW-1:0] id_imm;
    alu_op_e       id_op;

    logic [AW-1:0] rf_raddra;
    logic [AW-1:0] rf_raddrb;
    logic [DW-1:0] rf_douta;
    logic [DW-1:0] rf_doutb;

    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_din;

    logic          flush;

    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] ex_a;
    logic [DW-1:0] ex_b;
    logic [AW-1:0] ex_rd;
    logic          ex_we;
    alu_op_e       ex_op;

    // Surrounding core: decode, register file, write-back and execute.
    modport master (
        output id_valid, id_ra, id_rb, id_rd, id_we, id_use_imm, id_imm, id_op,
        output rf_douta, rf_doutb,
        output wb_we, wb_waddr, wb_din,
        output flush, ex_ready,
        input  id_ready, rf_raddra, rf_raddrb,
        input  ex_valid, ex_a, ex_b, ex_rd, ex_we, ex_op
    );

    // The operand-fetch stage itself.
    modport slave (
        input  id_valid, id_ra, id_rb, id_rd, id_we, id_use_imm, id_imm, id_op,
        input  rf_douta, rf_doutb,
        input  wb_we, wb_waddr, wb_din,
        input  flush, ex_ready,
        output id_ready, rf_raddra, rf_raddrb,
        output ex_valid, ex_a, ex_b, ex_rd, ex_we, ex_op
    );

endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register busy tracking: one bit per register with a write still in flight.
module operand_fetch_scoreboard
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            setEn_i,
    input  logic [AW-1:0]   setIdx_i,
    input  logic            clrEn_i,
    input  logic [AW-1:0]   clrIdx_i,
    input  logic            killEn_i,
    input  logic [AW-1:0]   killIdx_i,
    input  logic [AW-1:0]   ra_i,
    input  logic [AW-1:0]   rb_i,
    input  logic [AW-1:0]   rd_i,
    input  logic            useImm_i,
    input  logic            we_i,
    output logic [NREG-1:0] busyEff_o,
    output logic            hazard_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clrVec;
    logic [NREG-1:0] setVec;
    logic [NREG-1:0] killVec;

    // Decode set/clear/kill strobes into one-hot vectors over the register file.
    always_comb begin
        clrVec  = '0;
        setVec  = '0;
        killVec = '0;
        if (clrEn_i)  clrVec[clrIdx_i]   = 1'b1;
        if (setEn_i)  setVec[setIdx_i]   = 1'b1;
        if (killEn_i) killVec[killIdx_i] = 1'b1;
    end

    // A write-back landing this cycle resolves its hazard immediately; a new set wins over any clear.
    always_comb begin
        busyEff_o = busy_q & ~clrVec;
        hazard_o  = busyEff_o[ra_i]
                  || (!useImm_i && busyEff_o[rb_i])
                  || (we_i && busyEff_o[rd_i]);
        busy_d    = (busy_q & ~clrVec & ~killVec) | setVec;
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads both sources, bypasses write-back, stalls on busy registers.
module operand_fetch
    import core_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);

    logic            canAdvance;
    logic            hazard;
    logic            accept;
    logic            killEn;
    logic            wbHitA;
    logic            wbHitB;
    logic [DW-1:0]   opA;
    logic [DW-1:0]   opB;
    logic [NREG-1:0] unusedBusyEff;

    issue_t          exReg_q;
    issue_t          exReg_d;
    logic            exValid_q;
    logic            exValid_d;

    assign bus.rf_raddra = bus.id_ra;
    assign bus.rf_raddrb = bus.id_rb;

    // Handshake: accept only when the output slot frees up, no hazard, and no flush this cycle.
    always_comb begin
        canAdvance   = !exValid_q || bus.ex_ready;
        bus.id_ready = canAdvance && !hazard && !bus.flush;
        accept       = bus.id_valid && bus.id_ready;
        killEn       = bus.flush && exValid_q && exReg_q.we;
    end

    // Operand selection: the register file returns stale data on a same-cycle write, so forward wb_din.
    always_comb begin
        wbHitA = bus.wb_we && (bus.wb_waddr == bus.id_ra);
        wbHitB = bus.wb_we && (bus.wb_waddr == bus.id_rb);
        opA    = wbHitA ? bus.wb_din : bus.rf_douta;
        if (bus.id_use_imm) begin
            opB = bus.id_imm;
        end else begin
            opB = wbHitB ? bus.wb_din : bus.rf_doutb;
        end
    end

    // Output register next state: load on accept, drop valid on consume or flush, otherwise hold.
    always_comb begin
        exReg_d   = exReg_q;
        exValid_d = exValid_q;
        if (accept) begin
            exReg_d.a  = opA;
            exReg_d.b  = opB;
            exReg_d.rd = bus.id_rd;
            exReg_d.we = bus.id_we;
            exReg_d.op = bus.id_op;
            exValid_d  = 1'b1;
        end else if (bus.flush) begin
            exValid_d  = 1'b0;
        end else if (exValid_q && bus.ex_ready) begin
            exValid_d  = 1'b0;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exReg_q   <= '0;
            exValid_q <= 1'b0;
        end else begin
            exReg_q   <= exReg_d;
            exValid_q <= exValid_d;
        end
    end

    assign bus.ex_valid = exValid_q;
    assign bus.ex_a     = exReg_q.a;
    assign bus.ex_b     = exReg_q.b;
    assign bus.ex_rd    = exReg_q.rd;
    assign bus.ex_we    = exReg_q.we;
    assign bus.ex_op    = exReg_q.op;

    operand_fetch_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .setEn_i   (accept && bus.id_we),
        .setIdx_i  (bus.id_rd),
        .clrEn_i   (bus.wb_we),
        .clrIdx_i  (bus.wb_waddr),
        .killEn_i  (killEn),
        .killIdx_i (exReg_q.rd),
        .ra_i      (bus.id_ra),
        .rb_i      (bus.id_rb),
        .rd_i      (bus.id_rd),
        .useImm_i  (bus.id_use_imm),
        .we_i      (bus.id_we),
        .busyEff_o (unusedBusyEff),
        .hazard_o  (hazard)
    );

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed bench for operand_fetch against a behavioural pipeline model.
module tb_operand_fetch;
    import core_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    operand_fetch_if ofIf();

    operand_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ofIf)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Register file owned by the bench: asynchronous read, write at the clock edge.
    logic [DW-1:0] rf [NREG];
    assign ofIf.rf_douta = rf[ofIf.rf_raddra];
    assign ofIf.rf_doutb = rf[ofIf.rf_raddrb];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state.
    logic            mExValid;
    logic [DW-1:0]   mExA;
    logic [DW-1:0]   mExB;
    logic [AW-1:0]   mExRd;
    logic            mExWe;
    alu_op_e         mExOp;
    logic [NREG-1:0] mBusy;
    logic            autoExec;

    typedef struct {
        logic [AW-1:0] rd;
        int            cnt;
    } pend_t;
    pend_t pendQ[$];

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mExValid = 1'b0;
        mExA     = '0;
        mExB     = '0;
        mExRd    = '0;
        mExWe    = 1'b0;
        mExOp    = ALU_ADD;
        mBusy    = '0;
        pendQ.delete();
    endtask

    function automatic logic modelReady();
        logic [NREG-1:0] pendingNow;
        logic            stall;
        pendingNow = mBusy;
        if (ofIf.wb_we) pendingNow[ofIf.wb_waddr] = 1'b0;
        stall = pendingNow[ofIf.id_ra]
             || (!ofIf.id_use_imm && pendingNow[ofIf.id_rb])
             || (ofIf.id_we && pendingNow[ofIf.id_rd]);
        return (!mExValid || ofIf.ex_ready) && !stall && !ofIf.flush;
    endfunction

    task automatic checkOutput();
        checkVal("id_ready",  32'(ofIf.id_ready),  32'(modelReady()));
        checkVal("rf_raddra", 32'(ofIf.rf_raddra), 32'(ofIf.id_ra));
        checkVal("rf_raddrb", 32'(ofIf.rf_raddrb), 32'(ofIf.id_rb));
        checkVal("ex_valid",  32'(ofIf.ex_valid),  32'(mExValid));
        checkVal("ex_a",      32'(ofIf.ex_a),      32'(mExA));
        checkVal("ex_b",      32'(ofIf.ex_b),      32'(mExB));
        checkVal("ex_rd",     32'(ofIf.ex_rd),     32'(mExRd));
        checkVal("ex_we",     32'(ofIf.ex_we),     32'(mExWe));
        checkVal("ex_op",     32'(ofIf.ex_op),     32'(mExOp));
    endtask

    // Advance the model by one clock using the inputs that were applied for this cycle.
    task automatic commit();
        logic            acc;
        logic [DW-1:0]   va;
        logic [DW-1:0]   vb;
        logic [NREG-1:0] nb;
        if (!rst_n) begin
            resetModel();
            return;
        end
        acc = ofIf.id_valid && modelReady();
        va  = (ofIf.wb_we && ofIf.wb_waddr == ofIf.id_ra) ? ofIf.wb_din : rf[ofIf.id_ra];
        if (ofIf.id_use_imm)
            vb = ofIf.id_imm;
        else
            vb = (ofIf.wb_we && ofIf.wb_waddr == ofIf.id_rb) ? ofIf.wb_din : rf[ofIf.id_rb];
        nb = mBusy;
        if (ofIf.wb_we) nb[ofIf.wb_waddr] = 1'b0;
        if (ofIf.flush && mExValid && mExWe) nb[mExRd] = 1'b0;
        if (acc && ofIf.id_we) nb[ofIf.id_rd] = 1'b1;
        foreach (pendQ[i]) pendQ[i].cnt--;
        if (autoExec && mExValid && ofIf.ex_ready && !ofIf.flush && mExWe)
            pendQ.push_back('{rd: mExRd, cnt: int'($urandom_range(0, 4))});
        if (acc) begin
            mExValid = 1'b1;
            mExA     = va;
            mExB     = vb;
            mExRd    = ofIf.id_rd;
            mExWe    = ofIf.id_we;
            mExOp    = ofIf.id_op;
        end else if (ofIf.flush || (mExValid && ofIf.ex_ready)) begin
            mExValid = 1'b0;
        end
        mBusy = nb;
        if (ofIf.wb_we) rf[ofIf.wb_waddr] = ofIf.wb_din;
    endtask

    task automatic runCycle();
        #1;
        checkOutput();
        @(posedge clk);
        #1;
        commit();
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        logic [AW-1:0] idx;
        ofIf.id_valid   = ($urandom_range(0, 3) != 0);
        ofIf.id_ra      = AW'($urandom_range(0, NREG - 1));
        ofIf.id_rb      = AW'($urandom_range(0, NREG - 1));
        ofIf.id_rd      = AW'($urandom_range(0, NREG - 1));
        ofIf.id_we      = ($urandom_range(0, 4) < 3);
        ofIf.id_use_imm = ($urandom_range(0, 9) < 3);
        ofIf.id_imm     = DW'($urandom);
        ofIf.id_op      = alu_op_e'(OPW'($urandom_range(0, 15)));
        ofIf.ex_ready   = ($urandom_range(0, 9) < 7);
        ofIf.flush      = ($urandom_range(0, 24) == 0);
        ofIf.wb_we      = 1'b0;
        ofIf.wb_waddr   = AW'($urandom_range(0, NREG - 1));
        ofIf.wb_din     = DW'($urandom);
        if (pendQ.size() > 0 && pendQ[0].cnt <= 0 && $urandom_range(0, 1) == 1) begin
            ofIf.wb_we    = 1'b1;
            ofIf.wb_waddr = pendQ[0].rd;
            void'(pendQ.pop_front());
        end else if ($urandom_range(0, 9) == 0) begin
            idx = AW'($urandom_range(0, NREG - 1));
            if (!mBusy[idx]) begin
                ofIf.wb_we    = 1'b1;
                ofIf.wb_waddr = idx;
            end
        end
    endtask

    task automatic setInstr(input logic v, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                            input logic [AW-1:0] rd, input logic we, input logic ui,
                            input logic [DW-1:0] imm);
        ofIf.id_valid   = v;
        ofIf.id_ra      = ra;
        ofIf.id_rb      = rb;
        ofIf.id_rd      = rd;
        ofIf.id_we      = we;
        ofIf.id_use_imm = ui;
        ofIf.id_imm     = imm;
        ofIf.id_op      = ALU_ADD;
        ofIf.ex_ready   = 1'b1;
        ofIf.flush      = 1'b0;
        ofIf.wb_we      = 1'b0;
        ofIf.wb_waddr   = '0;
        ofIf.wb_din     = '0;
    endtask

    task automatic setWb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ofIf.wb_we    = 1'b1;
        ofIf.wb_waddr = a;
        ofIf.wb_din   = d;
    endtask

    // Reset asserted while an instruction sits in the output register.
    task automatic midReset();
        int            budget;
        logic [AW-1:0] bi;
        budget = 0;
        while (!mExValid && budget < 200) begin
            applyStimulus();
            runCycle();
            budget++;
        end
        checkVal("pre_reset_ex_valid", 32'(ofIf.ex_valid), 32'd1);
        bi = '0;
        for (int i = 0; i < NREG; i++) if (mBusy[i]) bi = AW'(i);
        setInstr(1'b0, bi, bi, bi, 1'b1, 1'b0, '0);
        ofIf.ex_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkVal("rst_ex_valid", 32'(ofIf.ex_valid), 32'd0);
        checkVal("rst_ex_a",     32'(ofIf.ex_a),     32'd0);
        checkVal("rst_ex_rd",    32'(ofIf.ex_rd),    32'd0);
        checkVal("rst_id_ready", 32'(ofIf.id_ready), 32'd1);
        @(posedge clk);
        #1;
        commit();
        @(negedge clk);
        runCycle();
        rst_n = 1'b1;
    endtask

    // Hand-computed scenarios pinning the model with literal expectations.
    task automatic directedTests();
        autoExec = 1'b0;
        rf[0] = 16'h0000;
        rf[1] = 16'h0011;
        rf[2] = 16'h0022;
        rf[3] = 16'h1234;
        rf[9] = 16'h9999;

        setInstr(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, '0);
        #1; checkVal("first_ready", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, '0);
        #1; checkVal("first_a", 32'(ofIf.ex_a), 32'h0011);
        checkVal("first_b", 32'(ofIf.ex_b), 32'h0022);
        runCycle();

        setInstr(1'b1, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0, '0);
        #1; checkVal("raw_stall", 32'(ofIf.id_ready), 32'd0);
        runCycle();

        setInstr(1'b1, 4'd3, 4'd0, 4'd4, 1'b0, 1'b0, '0);
        setWb(4'd3, 16'hBEEF);
        #1; checkVal("raw_bypass_ready", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0, '0);
        #1; checkVal("raw_a", 32'(ofIf.ex_a), 32'hBEEF);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd5, 4'd6, 1'b0, 1'b1, 16'h00FF);
        #1; checkVal("imm_ready", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        for (int i = 0; i < 3; i++) begin
            setInstr(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, '0);
            ofIf.ex_ready = 1'b0;
            #1; checkVal("bp_ready", 32'(ofIf.id_ready), 32'd0);
            checkVal("bp_valid", 32'(ofIf.ex_valid), 32'd1);
            checkVal("bp_b",     32'(ofIf.ex_b),     32'h00FF);
            checkVal("bp_rd",    32'(ofIf.ex_rd),    32'd6);
            runCycle();
        end

        setInstr(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, '0);
        #1; checkVal("bp_release_ready", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, '0);
        #1; checkVal("bp_next_a", 32'(ofIf.ex_a), 32'h0011);
        checkVal("bp_next_valid", 32'(ofIf.ex_valid), 32'd1);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, '0);
        #1; checkVal("waw_stall", 32'(ofIf.id_ready), 32'd0);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, '0);
        setWb(4'd7, 16'h7777);
        #1; checkVal("waw_release", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        setInstr(1'b1, 4'd7, 4'd0, 4'd8, 1'b0, 1'b0, '0);
        #1; checkVal("waw_busy_kept", 32'(ofIf.id_ready), 32'd0);
        runCycle();

        setInstr(1'b1, 4'd0, 4'd0, 4'd9, 1'b1, 1'b0, '0);
        setWb(4'd7, 16'h7070);
        #1; checkVal("flush_setup_ready", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        setInstr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, '0);
        ofIf.ex_ready = 1'b0;
        ofIf.flush    = 1'b1;
        #1; checkVal("flush_hold_rd", 32'(ofIf.ex_rd), 32'd9);
        checkVal("flush_block_ready", 32'(ofIf.id_ready), 32'd0);
        runCycle();

        setInstr(1'b1, 4'd9, 4'd9, 4'd10, 1'b0, 1'b0, '0);
        #1; checkVal("flush_valid", 32'(ofIf.ex_valid), 32'd0);
        checkVal("flush_r9_ready", 32'(ofIf.id_ready), 32'd1);
        runCycle();

        setInstr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, '0);
        #1; checkVal("flush_r9_a", 32'(ofIf.ex_a), 32'h9999);
        runCycle();
    endtask

    // Main sequence: reset, random traffic, reset mid-transfer, directed scenarios.
    initial begin
        for (int i = 0; i < NREG; i++) rf[i] = DW'($urandom);
        autoExec = 1'b1;
        rst_n    = 1'b0;
        setInstr(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
        resetModel();
        @(negedge clk);
        runCycle();
        runCycle();
        rst_n = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            applyStimulus();
            runCycle();
        end

        midReset();
        directedTests();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage between instruction decode and the ALU in the 16-bit core.
- Drives both read addresses of the 16x16 register file and captures the operands into an output pipeline register.
- Keeps a per-register busy scoreboard so an instruction never reads a register whose write is still in flight.
- Bypasses the write-back bus in the cycle a pending write lands, and hands operands to execute with a valid/ready handshake.

Parameters:
- DW, 16, datapath width (register and immediate width)
- AW, 4, register address width; the register file has 2**AW registers
- OPW, 4, ALU opcode width, passed through untouched

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_ra  in  AW  source A register
- id_rb  in  AW  source B register
- id_rd  in  AW  destination register
- id_we  in  1  instruction writes id_rd
- id_use_imm  in  1  operand B comes from id_imm, not id_rb
- id_imm  in  DW  immediate
- id_op  in  OPW  ALU opcode
- rf_raddra  out  AW  register file read address A; equals id_ra (combinational)
- rf_raddrb  out  AW  register file read address B; equals id_rb (combinational)
- rf_douta  in  DW  register file read data A (asynchronous read)
- rf_doutb  in  DW  register file read data B (asynchronous read)
- wb_we  in  1  write-back strobe; the same signal drives the register file write enable
- wb_waddr  in  AW  write-back address
- wb_din  in  DW  write-back data
- flush  in  1  kill the instruction held in the output register
- ex_valid  out  1  operands valid to execute
- ex_ready  in  1  execute consumes this cycle
- ex_a  out  DW  operand A
- ex_b  out  DW  operand B
- ex_rd  out  AW  destination register
- ex_we  out  1  destination write flag
- ex_op  out  OPW  opcode

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: ex_valid=0; ex_a, ex_b, ex_rd, ex_we, ex_op = 0; busy[15:0] = 0.
- The register file writes at the clock edge, so a same-cycle read returns the old value. This is why the bypass below is required.
- clr[i] = wb_we && wb_waddr==i.
- busy_eff[i] = busy[i] && !clr[i]. A write landing this cycle clears the hazard for that register in the same cycle.
- hazard = busy_eff[id_ra] || (!id_use_imm && busy_eff[id_rb]) || (id_we && busy_eff[id_rd]).
  - The rd check prevents two in-flight writes to the same register, so one busy bit per register is sufficient.
- id_ready = (!ex_valid || ex_ready) && !hazard && !flush. id_ready is combinational from id_* and wb_*.
- accept = id_valid && id_ready.
- Operand A = (clr[id_ra]) ? wb_din : rf_douta.
- Operand B = id_use_imm ? id_imm : (clr[id_rb] ? wb_din : rf_doutb).
- On accept: the output register loads operands, id_rd, id_we and id_op, and ex_valid=1. Latency is one cycle from accept to ex_valid.
- If ex_valid && ex_ready && !accept: ex_valid=0. The data fields hold their last values.
- If ex_valid && !ex_ready: all ex_* outputs hold stable.
- Busy update: busy_next = (busy & ~clr) | set, where set = one-hot(id_rd) when accept && id_we.
  - set wins over clr on the same index.
- flush:
  - Forces ex_valid=0 next cycle and blocks accept in the current cycle.
  - If ex_valid && ex_we, clears busy[ex_rd], because the killed instruction never writes back.
  - Does not affect instructions already past execute; their write-backs still clear busy normally.
  - flush with ex_valid=0 changes no state.
- A wb_we to a register that is not busy: the register file is still written; busy stays 0; the bypass still applies.
- Register 0 is an ordinary register with no hardwired zero.
- Reset asserted mid-operation: all state clears at once and any in-flight instruction is dropped.
  - After reset, the bench must not issue write-backs left over from before the reset; busy is already 0.
- Full throughput: with no hazards and ex_ready held at 1, one instruction is accepted per cycle.

Decomposition:
- Shared package core_pkg holds:
  - DW, AW and OPW constants
  - the ALU opcode enum that id_op/ex_op carry
  - a typedef for the issued-instruction bundle {a, b, rd, we, op}
- One natural sub-module: scoreboard. It holds the busy vector and takes set/clr/flush-clear. It outputs busy_eff and the hazard check for three addresses plus the use_imm qualifier.
- Operand mux and the output register stay in operand_fetch.

Test Plan:
- Reset with rst_n=0 mid-transfer -> ex_valid=0 asynchronously and busy=0. After release, a first instruction ra=1, rb=2, with R1=0x0011 and R2=0x0022 -> ex_a=0x0011, ex_b=0x0022 one cycle after accept.
- Back-to-back RAW: accept rd=3, we=1. Next instruction has ra=3 -> id_ready=0 while busy[3]=1. In the cycle wb_we=1, wb_waddr=3, wb_din=0xBEEF -> id_ready=1 and ex_a=0xBEEF next cycle, through the bypass rather than the old register file value.
- Immediate: rb=5 busy, id_use_imm=1, id_imm=0x00FF -> accepted with no stall; ex_b=0x00FF.
- Backpressure: ex_ready=0 for 3 cycles with a valid output -> id_ready=0 and ex_* stable. Then ex_ready=1 -> the next instruction is accepted the same cycle and presented the following cycle.
- WAW: an in-flight write to rd=7, then a new id_we instruction with rd=7 -> stall until the write-back to 7. A same-cycle set/clr on index 7 leaves busy[7]=1.
- Flush: the output register holds rd=9, we=1, and flush=1 -> ex_valid=0 next cycle and busy[9]=0. A subsequent instruction reading R9 is accepted immediately with no write-back.
